// File: rtl/enc_bundler_acc.sv
// Bundler accumulator: sums bound/shifted level HVs per bit over NUM_CHUNKS beats and thresholds the votes into one sparse HV.
// Optional out_density (popcount of out_hv) enabled by defining ENC_BUNDLER_DENSITY_EN.
module enc_bundler_acc #(
   parameter int unsigned HV_DIM          = 1024,
   parameter int unsigned FEATURES_PER_CC = 8,
   parameter int unsigned NUM_CHUNKS      = 8,
   parameter int unsigned CNT_W           = 7,
   parameter int unsigned THRESHOLD       = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [HV_DIM-1:0]           shifted_hv [FEATURES_PER_CC],
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [HV_DIM-1:0]           out_hv
`ifdef ENC_BUNDLER_DENSITY_EN
   ,
   output logic [$clog2(HV_DIM+1)-1:0] out_density
`endif
);

   localparam int unsigned SUM_W  = $clog2(FEATURES_PER_CC + 1);
   localparam int unsigned ADD_W  = ((CNT_W > SUM_W) ? CNT_W : SUM_W) + 1;
   localparam int unsigned BEAT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int unsigned DENS_W = $clog2(HV_DIM + 1);
   localparam logic [ADD_W-1:0]  CNT_MAX   = ADD_W'((2 ** CNT_W) - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_CHUNKS - 1);

   if ((THRESHOLD < 1) || (THRESHOLD > (2 ** CNT_W) - 1)) begin : g_bad_threshold
      $error("enc_bundler_acc: THRESHOLD out of range for CNT_W");
   end
   if (NUM_CHUNKS < 1) begin : g_bad_chunks
      $error("enc_bundler_acc: NUM_CHUNKS must be at least 1");
   end

   typedef enum logic {ST_ACCUM, ST_EMIT} state_t;

   state_t                r_state;
   logic [BEAT_W-1:0]     r_beat;
   logic [CNT_W-1:0]      r_cnt      [HV_DIM];
   logic                  r_out_valid;
   logic [HV_DIM-1:0]     r_out_hv;

   logic [FEATURES_PER_CC-1:0] w_col      [HV_DIM];
   logic [ADD_W-1:0]           w_add      [HV_DIM];
   logic [CNT_W-1:0]           w_cnt_next [HV_DIM];
   logic [HV_DIM-1:0]          w_bit;
   logic                       w_accept;
   logic                       w_last;

   function automatic logic [SUM_W-1:0] vote_count(input logic [FEATURES_PER_CC-1:0] v);
      logic [SUM_W-1:0] s;
      s = '0;
      for (int i = 0; i < FEATURES_PER_CC; i++) s = s + SUM_W'(v[i]);
      return s;
   endfunction

   // Per-bit saturating vote update and threshold on the updated count
   always_comb begin
      for (int j = 0; j < HV_DIM; j++) begin
         for (int i = 0; i < FEATURES_PER_CC; i++) w_col[j][i] = shifted_hv[i][j];
         w_add[j]      = ADD_W'(r_cnt[j]) + ADD_W'(vote_count(w_col[j]));
         w_cnt_next[j] = (w_add[j] > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(w_add[j]);
         w_bit[j]      = (w_cnt_next[j] >= CNT_W'(THRESHOLD));
      end
   end

   assign w_accept  = in_valid && (r_state == ST_ACCUM);
   assign w_last    = w_accept && (r_beat == LAST_BEAT);
   assign in_ready  = rst_n && (r_state == ST_ACCUM);
   assign out_valid = r_out_valid;
   assign out_hv    = r_out_hv;

`ifdef ENC_BUNDLER_DENSITY_EN
   logic [DENS_W-1:0] r_out_density;
   logic [DENS_W-1:0] w_density;

   always_comb begin
      w_density = '0;
      for (int j = 0; j < HV_DIM; j++) w_density = w_density + DENS_W'(w_bit[j]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_out_density <= '0;
      else if (w_last) r_out_density <= w_density;
   end

   assign out_density = r_out_density;
`endif

   // Accumulate votes, emit on the last beat, hold the result until downstream takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_ACCUM;
         r_beat      <= '0;
         r_out_valid <= 1'b0;
         r_out_hv    <= '0;
         for (int j = 0; j < HV_DIM; j++) r_cnt[j] <= '0;
      end else if (r_state == ST_ACCUM) begin
         if (w_last) begin
            r_beat      <= '0;
            r_out_hv    <= w_bit;
            r_out_valid <= 1'b1;
            r_state     <= ST_EMIT;
            for (int j = 0; j < HV_DIM; j++) r_cnt[j] <= '0;
         end else if (w_accept) begin
            r_beat <= r_beat + BEAT_W'(1);
            for (int j = 0; j < HV_DIM; j++) r_cnt[j] <= w_cnt_next[j];
         end
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
         r_state     <= ST_ACCUM;
      end
   end

endmodule
